// File: rtl/phase_arbiter_pkg.sv
// Shared types and widths for the phase arbiter slice.
// Widening REQ_ID_WIDTH and the enum is how more requesters would be added.
package phase_arbiter_pkg;

  localparam int PHASE_WIDTH  = 16;
  localparam int REQ_ID_WIDTH = 1;

  typedef enum logic [REQ_ID_WIDTH-1:0] {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ0) ? REQ1 : REQ0;
  endfunction

endpackage

// File: rtl/phase_arbiter_tag_fifo.sv
// In-order requester-ID FIFO; first-word-fall-through so the head ID is
// available combinationally in the same cycle as the result strobe.
module phase_arbiter_tag_fifo
  import phase_arbiter_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int SHIFT = 6
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           i_push,
  input  req_id_e        i_push_id,
  input  logic           i_pop,
  output req_id_e        o_pop_id,
  output logic           o_empty,
  output logic           o_full,
  output logic [SHIFT:0] o_count
);

  localparam logic [SHIFT:0]   FULL_COUNT = (SHIFT + 1)'(DEPTH);
  localparam logic [SHIFT:0]   ONE_COUNT  = (SHIFT + 1)'(1);
  localparam logic [SHIFT-1:0] ONE_PTR    = SHIFT'(1);

  req_id_e          r_mem [DEPTH];
  logic [SHIFT-1:0] r_wr_ptr;
  logic [SHIFT-1:0] r_rd_ptr;
  logic [SHIFT:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_COUNT);
  assign o_count   = r_count;
  assign o_pop_id  = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage carries no reset: entries are only read below r_count.
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_id;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + ONE_PTR;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + ONE_PTR;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + ONE_COUNT;
        2'b01:   r_count <= r_count - ONE_COUNT;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/phase_arbiter.sv
// Round-robin share of one pipelined phase unit between two requesters,
// with in-order ID tagging so each result is steered back to its owner.
module phase_arbiter
  import phase_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int INFLIGHT_DEPTH = 64,
  parameter int INFLIGHT_SHIFT = 6
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic signed [DATA_WIDTH-1:0]  req0_i,
  input  logic signed [DATA_WIDTH-1:0]  req0_q,
  input  logic                          req0_valid,
  output logic                          req0_ready,
  input  logic signed [DATA_WIDTH-1:0]  req1_i,
  input  logic signed [DATA_WIDTH-1:0]  req1_q,
  input  logic                          req1_valid,
  output logic                          req1_ready,
  output logic signed [DATA_WIDTH-1:0]  phase_in_i,
  output logic signed [DATA_WIDTH-1:0]  phase_in_q,
  output logic                          phase_in_strobe,
  output logic                          phase_enable,
  input  logic signed [PHASE_WIDTH-1:0] phase_result,
  input  logic                          phase_res_strobe,
  output logic signed [PHASE_WIDTH-1:0] out0_phase,
  output logic                          out0_strobe,
  output logic signed [PHASE_WIDTH-1:0] out1_phase,
  output logic                          out1_strobe,
  output logic [INFLIGHT_SHIFT:0]       inflight,
  output logic                          tag_err
);

  // Handshake: a sample transfers on a cycle where reqK_valid & reqK_ready.
  // Ready is combinational from both valids, so a requester must raise
  // valid independently of ready and may drop it again before a transfer.

  req_id_e                       r_rr;
  logic                          r_phase_enable;
  logic signed [DATA_WIDTH-1:0]  r_phase_in_i;
  logic signed [DATA_WIDTH-1:0]  r_phase_in_q;
  logic                          r_phase_in_strobe;
  logic signed [PHASE_WIDTH-1:0] r_out0_phase;
  logic signed [PHASE_WIDTH-1:0] r_out1_phase;
  logic                          r_out0_strobe;
  logic                          r_out1_strobe;
  logic                          r_tag_err;

  req_id_e                       w_winner;
  req_id_e                       w_pop_id;
  logic                          w_empty;
  logic                          w_full;
  logic                          w_grant_ok;
  logic                          w_push;
  logic                          w_pop;
  logic [INFLIGHT_SHIFT:0]       w_count;
  logic signed [DATA_WIDTH-1:0]  w_sel_i;
  logic signed [DATA_WIDTH-1:0]  w_sel_q;

  always_comb begin
    w_winner = REQ0;
    if (req0_valid && req1_valid) begin
      w_winner = r_rr;
    end else if (req1_valid) begin
      w_winner = REQ1;
    end
  end

  // A full FIFO blocks grants even when a pop lands in the same cycle.
  assign w_grant_ok = enable & ~w_full & ~reset;
  assign req0_ready = w_grant_ok & (w_winner == REQ0);
  assign req1_ready = w_grant_ok & (w_winner == REQ1);
  assign w_push     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign w_pop      = phase_res_strobe & ~w_empty;
  assign w_sel_i    = (w_winner == REQ1) ? req1_i : req0_i;
  assign w_sel_q    = (w_winner == REQ1) ? req1_q : req0_q;

  phase_arbiter_tag_fifo #(
    .DEPTH (INFLIGHT_DEPTH),
    .SHIFT (INFLIGHT_SHIFT)
  ) u_tag_fifo (
    .clock     (clock),
    .reset     (reset),
    .i_push    (w_push),
    .i_push_id (w_winner),
    .i_pop     (w_pop),
    .o_pop_id  (w_pop_id),
    .o_empty   (w_empty),
    .o_full    (w_full),
    .o_count   (w_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr              <= REQ0;
      r_phase_enable    <= 1'b0;
      r_phase_in_i      <= '0;
      r_phase_in_q      <= '0;
      r_phase_in_strobe <= 1'b0;
      r_out0_phase      <= '0;
      r_out1_phase      <= '0;
      r_out0_strobe     <= 1'b0;
      r_out1_strobe     <= 1'b0;
      r_tag_err         <= 1'b0;
    end else begin
      // Phase unit enable is held high whenever out of reset.
      r_phase_enable    <= 1'b1;
      r_phase_in_strobe <= w_push;
      if (w_push) begin
        r_phase_in_i <= w_sel_i;
        r_phase_in_q <= w_sel_q;
        r_rr         <= other_req(w_winner);
      end
      r_out0_strobe <= w_pop & (w_pop_id == REQ0);
      r_out1_strobe <= w_pop & (w_pop_id == REQ1);
      if (w_pop && (w_pop_id == REQ0)) begin
        r_out0_phase <= phase_result;
      end
      if (w_pop && (w_pop_id == REQ1)) begin
        r_out1_phase <= phase_result;
      end
      // A result with no recorded owner is dropped and flagged until reset.
      if (phase_res_strobe && w_empty) begin
        r_tag_err <= 1'b1;
      end
    end
  end

  assign phase_enable    = r_phase_enable;
  assign phase_in_i      = r_phase_in_i;
  assign phase_in_q      = r_phase_in_q;
  assign phase_in_strobe = r_phase_in_strobe;
  assign out0_phase      = r_out0_phase;
  assign out1_phase      = r_out1_phase;
  assign out0_strobe     = r_out0_strobe;
  assign out1_strobe     = r_out1_strobe;
  assign inflight        = w_count;
  assign tag_err         = r_tag_err;

endmodule
